// File: rtl/iir_biquad_sequencer.sv
// Sequential direct-form-I biquad: one multiply per cycle through an external
// combinational sign-magnitude multiplier. Optional sticky sat_flag via IIR_SAT_FLAG_EN.
module iir_biquad_sequencer #(
  parameter int WIDTH = 31,
  parameter int FRAC  = 16,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   coef_b0,
  input  logic [WIDTH:0]   coef_b1,
  input  logic [WIDTH:0]   coef_b2,
  input  logic [WIDTH:0]   coef_a1,
  input  logic [WIDTH:0]   coef_a2,
  output logic [WIDTH:0]   mul_a,
  output logic [WIDTH:0]   mul_b,
  input  logic [WIDTH:0]   mul_result,
  output logic [WIDTH:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef IIR_SAT_FLAG_EN
  ,
  output logic             sat_flag
`endif
);

  localparam int ACC_W = WIDTH + 1 + GUARD;

  if (FRAC >= WIDTH) begin : g_frac_check
    $error("FRAC must leave at least one integer magnitude bit");
  end

  typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

  state_t state, state_nxt;
  logic [2:0] tap;
  logic signed [ACC_W-1:0] acc, prod_p0, acc_sum;
  logic [WIDTH:0] x0, x1, x2, y1, y2;

  function automatic logic signed [ACC_W-1:0] to_twos(input logic [WIDTH:0] sm);
    logic signed [ACC_W-1:0] mag;
    mag = $signed({{(GUARD + 1){1'b0}}, sm[WIDTH-1:0]});
    to_twos = sm[WIDTH] ? -mag : mag;
  endfunction

  function automatic logic [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] v);
    abs_acc = v[ACC_W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
    sat_hit = abs_acc(v) > {{(GUARD + 1){1'b0}}, {WIDTH{1'b1}}};
  endfunction

  // Clamp the magnitude; a zero result is always emitted with a positive sign.
  function automatic logic [WIDTH:0] sat_sm(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-1:0] mag;
    mag = abs_acc(v);
    if (sat_hit(v))
      sat_sm = {v[ACC_W-1], {WIDTH{1'b1}}};
    else
      sat_sm = {v[ACC_W-1] && (mag != '0), mag[WIDTH-1:0]};
  endfunction

  assign prod_p0 = to_twos(mul_result);
  assign acc_sum = (tap < 3'd3) ? acc + prod_p0 : acc - prod_p0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MAC;
      end
      MAC: begin
        case (tap)
          3'd0: begin mul_a = x0; mul_b = coef_b0; end
          3'd1: begin mul_a = x1; mul_b = coef_b1; end
          3'd2: begin mul_a = x2; mul_b = coef_b2; end
          3'd3: begin mul_a = y1; mul_b = coef_a1; end
          3'd4: begin mul_a = y2; mul_b = coef_a2; end
          default: begin mul_a = '0; mul_b = '0; end
        endcase
        if (tap == 3'd4) state_nxt = HOLD;
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Product of the current tap is folded into acc on every MAC edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap       <= '0;
      acc       <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
`ifdef IIR_SAT_FLAG_EN
      sat_flag  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x0  <= in_data;
            acc <= '0;
            tap <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          tap <= tap + 3'd1;
          if (tap == 3'd4) begin
            out_data  <= sat_sm(acc_sum);
            out_valid <= 1'b1;
`ifdef IIR_SAT_FLAG_EN
            if (sat_hit(acc_sum)) sat_flag <= 1'b1;
`endif
          end
        end
        HOLD: begin
          if (out_ready) begin
            x2        <= x1;
            x1        <= x0;
            y2        <= y1;
            y1        <= out_data;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_sequencer.sv
// Randomized + directed bench for iir_biquad_sequencer with an exact multiplier
// model on mul_result and an arithmetic biquad reference model.
module tb_iir_biquad_sequencer;
  localparam int WIDTH = 31;
  localparam int FRAC  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] b0, b1, b2, a1, a2;
  logic [31:0] mul_a, mul_b, mul_result;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
`ifdef IIR_SAT_FLAG_EN
  logic        sat_flag;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] hx1, hx2, hy1, hy2;
  logic        sat_seen;

  always #5 clk = ~clk;

  iir_biquad_sequencer #(.WIDTH(WIDTH), .FRAC(FRAC), .GUARD(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_b0(b0), .coef_b1(b1), .coef_b2(b2), .coef_a1(a1), .coef_a2(a2),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef IIR_SAT_FLAG_EN
    , .sat_flag(sat_flag)
`endif
  );

  function automatic logic [31:0] sm_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a[30:0]) * 64'(b[30:0]);
    p = p >> FRAC;
    if (p > 64'h7FFF_FFFF) p = 64'h7FFF_FFFF;
    return {a[31] ^ b[31], p[30:0]};
  endfunction

  function automatic longint sm2i(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  always_comb mul_result = sm_mul(mul_a, mul_b);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    hx1 = '0; hx2 = '0; hy1 = '0; hy2 = '0; sat_seen = 1'b0;
  endtask

  task automatic model_step(input logic [31:0] x, output logic [31:0] y);
    longint s, m;
    logic [63:0] mv;
    s = sm2i(sm_mul(x, b0)) + sm2i(sm_mul(hx1, b1)) + sm2i(sm_mul(hx2, b2))
      - sm2i(sm_mul(hy1, a1)) - sm2i(sm_mul(hy2, a2));
    m = (s < 0) ? -s : s;
    if (m > 64'sd2147483647) begin
      m = 64'sd2147483647;
      sat_seen = 1'b1;
    end
    mv = 64'(m);
    y = (s == 0) ? 32'd0 : {(s < 0), mv[30:0]};
    hx2 = hx1; hx1 = x; hy2 = hy1; hy1 = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic set_coefs(input logic [31:0] c0, c1, c2, c3, c4);
    b0 = c0; b1 = c1; b2 = c2; a1 = c3; a2 = c4;
  endtask

  // One full transaction: accept, check 5-edge latency, backpressure, handshake.
  task automatic run_sample(input logic [31:0] x, input int hold, output logic [31:0] y);
    logic [31:0] exp_y;
    @(negedge clk);
    check_val("in_ready_idle", in_ready, 1'b1);
    in_data = x; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_val("lat_e4_low", out_valid, 1'b0);
    @(posedge clk);
    #1 check_val("lat_e5_high", out_valid, 1'b1);
    y = out_data;
    model_step(x, exp_y);
    check_val("out_data_model", y, exp_y);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      in_data = $urandom;
      @(posedge clk); #1;
      check_val("hold_data", out_data, y);
      check_val("hold_valid", out_valid, 1'b1);
      check_val("hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("hs_valid_drop", out_valid, 1'b0);
    check_val("hs_in_ready", in_ready, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] y;
    logic [31:0] xr;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    set_coefs(0, 0, 0, 0, 0);
    model_clear();
    @(posedge clk); #1;
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_data", out_data, 32'd0);
    check_val("rst_mul_a", mul_a, 32'd0);
    check_val("rst_mul_b", mul_b, 32'd0);
    check_val("rst_in_ready", in_ready, 1'b1);
    do_reset();

    // Passthrough
    set_coefs(32'h0001_0000, 0, 0, 0, 0);
    run_sample(32'h0003_0000, 0, y);
    check_val("passthrough", y, 32'h0003_0000);
`ifdef IIR_SAT_FLAG_EN
    check_val("sat_flag_clear", sat_flag, 1'b0);
`endif

    // Sign handling, including -0 input
    do_reset();
    set_coefs(32'h0000_8000, 0, 0, 0, 0);
    run_sample(32'h8002_0000, 1, y);
    check_val("neg_half", y, 32'h8001_0000);
    run_sample(32'h8000_0000, 0, y);
    check_val("neg_zero", y, 32'h0000_0000);

    // Recursion
    do_reset();
    set_coefs(32'h0001_0000, 0, 0, 32'h8000_8000, 0);
    run_sample(32'h0001_0000, 0, y); check_val("rec0", y, 32'h0001_0000);
    run_sample(32'h0000_0000, 0, y); check_val("rec1", y, 32'h0000_8000);
    run_sample(32'h0000_0000, 0, y); check_val("rec2", y, 32'h0000_4000);

    // Saturation
    do_reset();
    set_coefs(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0, 0);
    run_sample(32'h4000_0000, 0, y);
    run_sample(32'h4000_0000, 0, y);
    run_sample(32'h4000_0000, 0, y);
    check_val("sat_pos", y, 32'h7FFF_FFFF);
`ifdef IIR_SAT_FLAG_EN
    check_val("sat_flag_set", sat_flag, 1'b1);
`endif

    // Backpressure for 10 cycles
    do_reset();
    set_coefs(32'h0001_0000, 0, 0, 0, 0);
    run_sample(32'h8005_0000, 10, y);
    check_val("bp_data", y, 32'h8005_0000);

    // Reset at tap 2, then the recursion sequence must reproduce
    do_reset();
    set_coefs(32'h0001_0000, 0, 0, 32'h8000_8000, 0);
    run_sample(32'h0001_0000, 0, y);
    @(negedge clk);
    in_data = 32'h0001_0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("midrst_out_valid", out_valid, 1'b0);
    check_val("midrst_in_ready", in_ready, 1'b1);
    check_val("midrst_mul_a", mul_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    run_sample(32'h0001_0000, 0, y); check_val("mr_rec0", y, 32'h0001_0000);
    run_sample(32'h0000_0000, 0, y); check_val("mr_rec1", y, 32'h0000_8000);
    run_sample(32'h0000_0000, 0, y); check_val("mr_rec2", y, 32'h0000_4000);

    // Randomized coefficients and samples against the model
    for (int r = 0; r < 3; r++) begin
      do_reset();
      set_coefs({1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0001_8000))},
                {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0001_0000))},
                {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0001_0000))},
                {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0000_C000))},
                {1'($urandom_range(0, 1)), 31'($urandom_range(0, 32'h0000_8000))});
      for (int i = 0; i < 12; i++) begin
        xr = {1'($urandom_range(0, 1)), 31'($urandom_range(0, (r == 2) ? 32'h7FFF_FFFF : 32'h00FF_FFFF))};
        run_sample(xr, $urandom_range(0, 3), y);
      end
`ifdef IIR_SAT_FLAG_EN
      check_val("rand_sat_flag", sat_flag, sat_seen);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iir_biquad_sequencer.md
Name: iir_biquad_sequencer

Overview:
- Sequential direct-form-I biquad section for the mixed IIR filter: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2].
- Sits directly upstream of the shared combinational sign-magnitude fixed-point multiplier. Drives its two operands one tap per cycle, then accumulates the returned products.
- Five multiply cycles per sample; ready/valid on both the sample input and the output.

Parameters:
- WIDTH, 31, MSB index of every data word (word = WIDTH+1 bits: bit WIDTH is sign, bits WIDTH-1:0 are magnitude).
- FRAC, 16, fractional bits in the magnitude (1.0 = 1<<FRAC).
- GUARD, 4, extra accumulator bits above WIDTH+1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_data  in  WIDTH+1  sample x[n], sign-magnitude
- in_valid  in  1  sample present
- in_ready  out  1  block can accept a sample
- coef_b0, coef_b1, coef_b2, coef_a1, coef_a2  in  WIDTH+1 each  coefficients, sign-magnitude, static while busy
- mul_a  out  WIDTH+1  multiplier operand A
- mul_b  out  WIDTH+1  multiplier operand B
- mul_result  in  WIDTH+1  multiplier product, same cycle (combinational path)
- out_data  out  WIDTH+1  y[n], sign-magnitude
- out_valid  out  1  y[n] present
- out_ready  in  1  consumer accepts y[n]

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous and active-high.
- Reset values (next edge with rst=1, from any state):
  - state=IDLE, tap=0, acc=0
  - x0, x1, x2, y1, y2 history all 0
  - out_data=0, out_valid=0
  - mul_a=0, mul_b=0
  - in_ready=1 once out of reset
- States: IDLE, MAC, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch x0=in_data, acc=0, tap=0, go to MAC.
- MAC (tap 0..4), mul_a/mul_b per tap:
  - tap 0: x0, b0
  - tap 1: x1, b1
  - tap 2: x2, b2
  - tap 3: y1, a1
  - tap 4: y2, a2
  - Each edge: convert mul_result to two's complement (−0 → 0). Taps 0–2 add to acc; taps 3–4 subtract from acc. Then tap+1.
  - On the tap-4 edge: out_data = sat(acc_final), out_valid=1, go to HOLD.
  - mul_a=mul_b=0 outside MAC.
- Latency: acceptance edge E0, MAC edges E1..E5; out_valid is high after E5. Next sample accepted no earlier than the edge after the output handshake, so throughput is at most one sample per 7 cycles.
- sat(): acc is WIDTH+1+GUARD bits, two's complement.
  - |acc| > 2^WIDTH−1 → magnitude all ones, sign kept.
  - Otherwise the magnitude is exact.
  - A zero result is always emitted with sign=0 (never −0).
- HOLD:
  - out_data and out_valid are stable while out_ready=0; in_ready=0.
  - On out_ready=1: x2←x1, x1←x0, y2←y1, y1←out_data (the saturated value), out_valid←0, go to IDLE.
- in_ready=0 in MAC and HOLD. in_valid is ignored there.
- Coefficient changes during MAC/HOLD are undefined; the bench must not do this.
- Reset mid-operation discards the in-flight sample and all history; there is no partial output.

Optional Feature:
- Macro: IIR_SAT_FLAG_EN.
- Defined:
  - Adds output port sat_flag (1 bit), reset 0.
  - Set on the tap-4 edge when sat() clamps.
  - Sticky until rst.
- Undefined: port absent; saturation behaviour unchanged.

Test Plan:
- Bench setup: the bench drives mul_result from an exact reference model, not the team multiplier. The model computes the sign-magnitude product truncated to FRAC fractional bits and saturates the magnitude at 2^WIDTH−1.
- Passthrough: b0=0x00010000, others 0; x=0x00030000 → out_data=0x00030000; out_valid rises exactly 5 edges after acceptance.
- Sign handling: b0=0x00008000 (0.5); x=0x80020000 (−2.0) → out_data=0x80010000. Then x=0x80000000 (−0) → out_data=0x00000000, sign bit 0.
- Recursion: b0=0x00010000, a1=0x80008000 (−0.5); x = 0x00010000, 0, 0 → outputs 0x00010000, 0x00008000, 0x00004000.
- Saturation: b0=b1=b2=0x00010000; x = 0x40000000 ×3 → third output = 0x7FFFFFFF; sat_flag=1 when IIR_SAT_FLAG_EN is defined.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_data stable, in_ready=0, in_valid pulses ignored. out_ready=1 → out_valid drops next edge, in_ready=1.
- Reset mid-MAC: assert rst at tap 2 → next edge out_valid=0, in_ready=1. The following impulse 0x00010000 with a1 recursion reproduces the fresh sequence from the Recursion case.
